// File: rtl/div_u.sv
// ============================================================================
//  Module   : div_u
//  Purpose  : 16-bit unsigned restoring divider. One quotient bit per cycle,
//             MSB first. A divide by zero completes immediately with
//             result = {N, 16'hFFFF} and the div_zero flag set.
//  Ports    : clk      - clock, rising edge
//             n_rst    - asynchronous active-low reset
//             N, D     - dividend / divisor, captured on the accept edge
//             start    - request, sampled only while idle
//             dtype    - operation type; the block acts only on DTYPE_CODE
//             result   - registered {remainder[15:0], quotient[15:0]}
//             done     - one-cycle completion pulse (FIN state)
//             busy     - high whenever the FSM is not idle
//             div_zero - divisor was zero in the last completed operation
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_u #(
    parameter logic [3:0] DTYPE_CODE = 4'h3
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [15:0] N,
    input  logic [15:0] D,
    input  logic        start,
    input  logic [3:0]  dtype,
    output logic [31:0] result,
    output logic        done,
    output logic        busy,
    output logic        div_zero
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_FIN  = 2'd2;

    localparam logic [4:0] c_ITER = 5'd16;

    logic [1:0]  state_q,    state_d;
    logic [15:0] rem_q,      rem_d;
    logic [15:0] quo_q,      quo_d;
    logic [15:0] div_q,      div_d;
    logic [4:0]  cnt_q,      cnt_d;
    logic [31:0] result_q,   result_d;
    logic        div_zero_q, div_zero_d;

    logic        w_accept;
    logic        w_d_zero;
    logic        w_last;
    logic [16:0] w_shift;
    logic [16:0] w_trial;
    logic [15:0] w_rem_step;
    logic [15:0] w_quo_step;

    assign w_accept = (state_q == c_IDLE) && start && (dtype == DTYPE_CODE);
    assign w_d_zero = (D == 16'd0);
    assign w_last   = (cnt_q == 5'd1);

    // One restoring step. The quotient register initially holds the
    // dividend; its MSB feeds the remainder while result bits enter at LSB.
    assign w_shift    = {rem_q, quo_q[15]};
    assign w_trial    = w_shift - {1'b0, div_q};
    // trial[16] set means the subtraction borrowed: keep the shifted value.
    assign w_rem_step = w_trial[16] ? w_shift[15:0] : w_trial[15:0];
    assign w_quo_step = {quo_q[14:0], ~w_trial[16]};

    // ------------------------------------------------------------------
    // State register and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= c_IDLE;
            rem_q      <= 16'd0;
            quo_q      <= 16'd0;
            div_q      <= 16'd0;
            cnt_q      <= 5'd0;
            result_q   <= 32'h0000_0000;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            div_zero_q <= div_zero_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE: begin
                if (w_accept) begin
                    state_d = w_d_zero ? c_FIN : c_CALC;
                end
            end
            c_CALC: begin
                if (w_last) begin
                    state_d = c_FIN;
                end
            end
            c_FIN:   state_d = c_IDLE;
            default: state_d = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        rem_d      = rem_q;
        quo_d      = quo_q;
        div_d      = div_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        div_zero_d = div_zero_q;

        case (state_q)
            c_IDLE: begin
                if (w_accept) begin
                    if (w_d_zero) begin
                        result_d   = {N, 16'hFFFF};
                        div_zero_d = 1'b1;
                    end else begin
                        rem_d = 16'd0;
                        quo_d = N;
                        div_d = D;
                        cnt_d = c_ITER;
                    end
                end
            end
            c_CALC: begin
                rem_d = w_rem_step;
                quo_d = w_quo_step;
                cnt_d = cnt_q - 5'd1;
                if (w_last) begin
                    result_d   = {w_rem_step, w_quo_step};
                    div_zero_d = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        done     = (state_q == c_FIN);
        busy     = (state_q != c_IDLE);
        result   = result_q;
        div_zero = div_zero_q;
    end

endmodule

`default_nettype wire
